// File: rtl/eth_hdr_rx_8.sv
`default_nettype none
// ============================================================================
//  Module   : eth_hdr_rx_8
//  Purpose  : Byte-wide Ethernet header parser. Captures dest/src/EtherType
//             from the first 14 bytes of each frame and forwards the rest as
//             a payload stream. Flags short frames and keeps saturating
//             good/bad frame counters.
//  Options  : ETH_HDR_RX_MAC_FILTER_EN - destination MAC filter (local
//             station address or broadcast); frames that miss are dropped.
//  Revision : 1.0  initial release
// ============================================================================
module eth_hdr_rx_8 #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   input  logic              s_axis_tuser,
   input  logic [47:0]       local_mac,
   output logic              m_hdr_valid,
   output logic [47:0]       m_hdr_dest_mac,
   output logic [47:0]       m_hdr_src_mac,
   output logic [15:0]       m_hdr_type,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,
   output logic              er_short,
   output logic              er_filtered,
   output logic [CNT_W-1:0]  cnt_good,
   output logic [CNT_W-1:0]  cnt_bad
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HDR     = 2'd1,
`ifdef ETH_HDR_RX_MAC_FILTER_EN
      S_PAYLOAD = 2'd2,
      S_DROP    = 2'd3
`else
      S_PAYLOAD = 2'd2
`endif
   } state_t;

   state_t                  state, state_nx;
   logic [3:0]              idx, idx_nx;
   logic                    prev_v;
   // Header bytes shift in at the bottom; after 14 beats byte 0 sits at the top.
   logic [14*DATA_W-1:0]    sh;

   logic take, fwd, hdr_fire, short_ev, good_ev, bad_ev;

`ifdef ETH_HDR_RX_MAC_FILTER_EN
   logic        filt_ev;
   logic [47:0] dest_cand;
   logic        dest_ok;
   // Destination is complete on byte 5: bytes 0..4 from the shifter plus the live byte.
   assign dest_cand = {sh[5*DATA_W-1:0], s_axis_tdata};
   assign dest_ok   = (dest_cand == local_mac) || (dest_cand == 48'hFFFF_FFFF_FFFF);
`else
   logic unused_mac;
   assign unused_mac  = ^local_mac;
   assign er_filtered = 1'b0;
`endif

   // State, header index and previous-valid tracker.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         idx    <= 4'd0;
         prev_v <= 1'b1;   // forces an idle cycle before the first accepted frame
      end else begin
         state  <= state_nx;
         idx    <= idx_nx;
         prev_v <= s_axis_tvalid;
      end
   end

   // Next-state decode and per-beat event strobes.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      take     = 1'b0;
      fwd      = 1'b0;
      hdr_fire = 1'b0;
      short_ev = 1'b0;
      good_ev  = 1'b0;
      bad_ev   = 1'b0;
`ifdef ETH_HDR_RX_MAC_FILTER_EN
      filt_ev  = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            // Only a rising tvalid marks a frame start; a mid-frame beat is ignored.
            if (s_axis_tvalid && !prev_v) begin
               take = 1'b1;
               if (s_axis_tlast) begin
                  short_ev = 1'b1;
               end else begin
                  state_nx = S_HDR;
                  idx_nx   = 4'd1;
               end
            end
         end
         S_HDR: begin
            if (s_axis_tvalid) begin
               take = 1'b1;
               if (s_axis_tlast) begin
                  short_ev = 1'b1;
                  state_nx = S_IDLE;
               end else if (idx == 4'd13) begin
                  state_nx = S_PAYLOAD;
                  idx_nx   = 4'd14;   // marks "next beat is first payload byte"
               end else begin
                  idx_nx = idx + 4'd1;
`ifdef ETH_HDR_RX_MAC_FILTER_EN
                  if (idx == 4'd5 && !dest_ok) begin
                     state_nx = S_DROP;
                     filt_ev  = 1'b1;
                  end
`endif
               end
            end
         end
         S_PAYLOAD: begin
            if (s_axis_tvalid) begin
               fwd      = 1'b1;
               hdr_fire = (idx == 4'd14);
               idx_nx   = 4'd15;
               if (s_axis_tlast) begin
                  state_nx = S_IDLE;
                  good_ev  = !s_axis_tuser;
                  bad_ev   = s_axis_tuser;
               end
            end
         end
`ifdef ETH_HDR_RX_MAC_FILTER_EN
         S_DROP: begin
            // Keep counting header bytes so a short filtered frame still reports short.
            if (s_axis_tvalid) begin
               if (s_axis_tlast) begin
                  state_nx = S_IDLE;
                  short_ev = (idx <= 4'd13);
               end else if (idx != 4'd14) begin
                  idx_nx = idx + 4'd1;
               end
            end
         end
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   // Registered datapath: header capture, payload stream, error pulses, counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh             <= '0;
         m_hdr_valid    <= 1'b0;
         m_hdr_dest_mac <= '0;
         m_hdr_src_mac  <= '0;
         m_hdr_type     <= '0;
         m_axis_tdata   <= '0;
         m_axis_tvalid  <= 1'b0;
         m_axis_tlast   <= 1'b0;
         m_axis_tuser   <= 1'b0;
         er_short       <= 1'b0;
         cnt_good       <= '0;
         cnt_bad        <= '0;
      end else begin
         if (take) begin
            sh <= {sh[13*DATA_W-1:0], s_axis_tdata};
         end
         m_hdr_valid <= hdr_fire;
         if (hdr_fire) begin
            m_hdr_dest_mac <= sh[14*DATA_W-1:8*DATA_W];
            m_hdr_src_mac  <= sh[8*DATA_W-1:2*DATA_W];
            m_hdr_type     <= sh[2*DATA_W-1:0];
         end
         if (fwd) begin
            m_axis_tdata <= s_axis_tdata;
         end
         m_axis_tvalid <= fwd;
         m_axis_tlast  <= fwd && s_axis_tlast;
         m_axis_tuser  <= fwd && s_axis_tlast && s_axis_tuser;
         er_short      <= short_ev;
         if (good_ev && (cnt_good != {CNT_W{1'b1}})) begin
            cnt_good <= cnt_good + 1'b1;
         end
         if ((bad_ev || short_ev) && (cnt_bad != {CNT_W{1'b1}})) begin
            cnt_bad <= cnt_bad + 1'b1;
         end
      end
   end

`ifdef ETH_HDR_RX_MAC_FILTER_EN
   // Filter miss pulse, one cycle after byte 5.
   always_ff @(posedge clk) begin
      if (rst) begin
         er_filtered <= 1'b0;
      end else begin
         er_filtered <= filt_ev;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_hdr_rx_8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_hdr_rx_8
//  Purpose  : Scoreboard bench for eth_hdr_rx_8 (CNT_W = 4). Stimulus pushes
//             expected header/payload/error events; a monitor on the falling
//             edge pops and compares whatever the DUT presents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eth_hdr_rx_8;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tlast, s_tuser;
   logic [47:0] local_mac;
   logic        m_hdr_valid;
   logic [47:0] m_dest, m_src;
   logic [15:0] m_type;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tlast, m_tuser;
   logic        er_short, er_filtered;
   logic [CNT_W-1:0] cnt_good, cnt_bad;

   eth_hdr_rx_8 #(.DATA_W(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .local_mac(local_mac),
      .m_hdr_valid(m_hdr_valid), .m_hdr_dest_mac(m_dest),
      .m_hdr_src_mac(m_src), .m_hdr_type(m_type),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .er_short(er_short), .er_filtered(er_filtered),
      .cnt_good(cnt_good), .cnt_bad(cnt_bad)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       last;
      logic       user;
      logic       first;
   } pl_t;

   typedef struct {
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] typ;
   } hdr_t;

   pl_t  pl_q[$];
   hdr_t hdr_q[$];
   int   exp_short = 0;
   int   exp_filt  = 0;
   int   m_good = 0;
   int   m_bad  = 0;
   int   errors = 0;
   int   checks = 0;

   localparam logic [47:0] MAC_A = 48'h02_00_00_00_00_01;
   localparam logic [47:0] MAC_B = 48'h02_00_00_00_00_02;
   localparam logic [47:0] MAC_X = 48'h02_00_00_00_00_09;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: DUT output with nothing expected", name);
   endtask

   function automatic logic [7:0] frame_byte(input logic [47:0] dest, input logic [47:0] src,
                                             input logic [15:0] typ, input int i);
      if (i < 6)        return dest[47-8*i -: 8];
      else if (i < 12)  return src[47-8*(i-6) -: 8];
      else if (i == 12) return typ[15:8];
      else if (i == 13) return typ[7:0];
      else              return 8'((i * 7 + 3) & 255);
   endfunction

   function automatic int sat_inc(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   // Push expectations for one frame, then drive it; rst_at>0 asserts rst for bytes rst_at, rst_at+1.
   task automatic send_frame(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] typ,
                             input int len, input bit bad, input int rst_at, input int gap);
      bit filt;
      filt = 1'b0;
`ifdef ETH_HDR_RX_MAC_FILTER_EN
      filt = (dest != local_mac) && (dest != BCAST) && (len > 6);
`endif
      if (len <= 14) begin
         exp_short++;
         m_bad = sat_inc(m_bad);
      end else if (filt) begin
         exp_filt++;
      end else begin
         if (rst_at == 0 || rst_at > 14) begin
            hdr_t h;
            h.dest = dest; h.src = src; h.typ = typ;
            hdr_q.push_back(h);
         end
         for (int i = 14; i < len; i++) begin
            if (rst_at == 0 || i < rst_at) begin
               pl_t p;
               p.d     = frame_byte(dest, src, typ, i);
               p.last  = (i == len - 1);
               p.user  = (i == len - 1) && bad;
               p.first = (i == 14);
               pl_q.push_back(p);
            end
         end
         if (rst_at != 0) begin
            m_good = 0;
            m_bad  = 0;
         end else if (bad) begin
            m_bad = sat_inc(m_bad);
         end else begin
            m_good = sat_inc(m_good);
         end
      end
      for (int i = 0; i < len; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = frame_byte(dest, src, typ, i);
         s_tlast  = (i == len - 1);
         s_tuser  = (i == len - 1) && bad;
         rst      = (rst_at != 0) && (i >= rst_at) && (i < rst_at + 2);
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = 8'h00; rst = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      check("cnt_good", cnt_good, m_good);
      check("cnt_bad",  cnt_bad,  m_bad);
   endtask

   // Monitor: every DUT output event must match the head of its queue.
   always @(negedge clk) begin
      if (m_tvalid) begin
         if (pl_q.size() == 0) begin
            unexpected("payload");
         end else begin
            pl_t e;
            e = pl_q.pop_front();
            check("payload", {m_tdata, m_tlast, m_tuser}, {e.d, e.last, e.user});
            check("hdr_valid_align", m_hdr_valid, e.first);
         end
      end else if (m_hdr_valid) begin
         unexpected("hdr_valid_without_payload");
      end
      if (m_hdr_valid) begin
         if (hdr_q.size() == 0) begin
            unexpected("header");
         end else begin
            hdr_t h;
            h = hdr_q.pop_front();
            check("header", {m_dest, m_src, m_type}, {h.dest, h.src, h.typ});
         end
      end
      if (er_short) begin
         if (exp_short == 0) unexpected("er_short");
         else begin
            checks++;
            exp_short--;
         end
      end
      if (er_filtered) begin
         if (exp_filt == 0) unexpected("er_filtered");
         else begin
            checks++;
            exp_filt--;
         end
      end
   end

   initial begin
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = 8'h00;
      local_mac = MAC_A;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            {m_hdr_valid, m_dest, m_src, m_type, m_tdata, m_tvalid, m_tlast, m_tuser, er_short, er_filtered},
            '0);
      check("reset_counters", {cnt_good, cnt_bad}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      send_frame(MAC_A, MAC_B, 16'h0800, 64, 1'b0, 0, 2);   // good frame
      send_frame(MAC_A, MAC_B, 16'h0800, 10, 1'b0, 0, 2);   // short
      send_frame(MAC_A, MAC_B, 16'h86DD, 60, 1'b1, 0, 2);   // bad (tuser)
      send_frame(MAC_B, MAC_A, 16'h0806, 14, 1'b0, 0, 2);   // tlast on byte 13: short
      send_frame(MAC_B, MAC_A, 16'h0806, 15, 1'b0, 0, 2);   // one payload byte
      send_frame(MAC_A, MAC_B, 16'h0800,  1, 1'b0, 0, 2);   // tlast on byte 0
      send_frame(MAC_A, MAC_B, 16'h0800, 100, 1'b0, 20, 12); // reset mid-frame
      send_frame(MAC_B, MAC_A, 16'h1234, 64, 1'b0, 0, 2);   // clean frame after reset
      send_frame(MAC_X, MAC_B, 16'h0800, 64, 1'b0, 0, 2);   // filtered when filter built in
      send_frame(BCAST, MAC_B, 16'h0800, 64, 1'b0, 0, 2);   // broadcast passes
      for (int k = 0; k < 17; k++) begin
         send_frame(MAC_A, MAC_B, 16'(16'h0900 + k), 20, 1'b0, 0, 1);
      end
      check("cnt_good_saturated", cnt_good, CNT_MAX);

      repeat (4) @(posedge clk);
      #1;
      check("payload_queue_drained", pl_q.size(), 0);
      check("header_queue_drained", hdr_q.size(), 0);
      check("short_events_seen", exp_short, 0);
      check("filter_events_seen", exp_filt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
